pipe_id_stage: RTL

PIPE_ID_STAGE -- requirements
Module: pipe_id_stage

---
 rtl/pipe_id_stage.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/pipe_id_stage.sv
// pipe_id_stage: MIPS-style instruction decode stage with 32x32 register file, load-use stall and branch/jump resolution.
// Optional feature: define PIPE_ID_FWD_EN for EX/MEM operand forwarding; without it every RAW hazard on EX/MEM stalls.
module pipe_id_stage (
   input  logic        clock,
   input  logic        resetn,
   input  logic [31:0] inst,
   input  logic [31:0] dpc4,
   input  logic        ewreg,
   input  logic        em2reg,
   input  logic [4:0]  ern,
   input  logic [31:0] ealu,
   input  logic        mwreg,
   input  logic        mm2reg,
   input  logic [4:0]  mrn,
   input  logic [31:0] malu,
   input  logic [31:0] mmo,
   input  logic        wwreg,
   input  logic [4:0]  wrn,
   input  logic [31:0] wdi,
   output logic        dwreg,
   output logic        dm2reg,
   output logic        dwmem,
   output logic        daluimm,
   output logic        dshift,
   output logic        djal,
   output logic [3:0]  daluc,
   output logic [31:0] da,
   output logic [31:0] db,
   output logic [31:0] dimm,
   output logic [4:0]  drn,
   output logic        wpcir,
   output logic [1:0]  pcsource,
   output logic [31:0] bpc,
   output logic [31:0] jpc
);

   logic [5:0]  op, func;
   logic [4:0]  rs, rt, rd, sa;
   logic [15:0] imm;
   logic        r_type, nop, wreg, sext, uses_rs, uses_rt, stall;
   logic        i_add, i_sub, i_and, i_or, i_xor, i_sll, i_srl, i_sra, i_jr;
   logic        i_addi, i_andi, i_ori, i_xori, i_lw, i_sw, i_beq, i_bne, i_lui, i_j, i_jal;
   logic [31:0] regs [32];
   logic [31:0] rf_a, rf_b;

   assign op   = inst[31:26];
   assign rs   = inst[25:21];
   assign rt   = inst[20:16];
   assign rd   = inst[15:11];
   assign sa   = inst[10:6];
   assign func = inst[5:0];
   assign imm  = inst[15:0];

   assign r_type = (op == 6'b000000);
   assign i_add  = r_type && (func == 6'b100000);
   assign i_sub  = r_type && (func == 6'b100010);
   assign i_and  = r_type && (func == 6'b100100);
   assign i_or   = r_type && (func == 6'b100101);
   assign i_xor  = r_type && (func == 6'b100110);
   assign i_sll  = r_type && (func == 6'b000000);
   assign i_srl  = r_type && (func == 6'b000010);
   assign i_sra  = r_type && (func == 6'b000011);
   assign i_jr   = r_type && (func == 6'b001000);
   assign i_addi = (op == 6'b001000);
   assign i_andi = (op == 6'b001100);
   assign i_ori  = (op == 6'b001101);
   assign i_xori = (op == 6'b001110);
   assign i_lw   = (op == 6'b100011);
   assign i_sw   = (op == 6'b101011);
   assign i_beq  = (op == 6'b000100);
   assign i_bne  = (op == 6'b000101);
   assign i_lui  = (op == 6'b001111);
   assign i_j    = (op == 6'b000010);
   assign i_jal  = (op == 6'b000011);

   // The all-zero word is the canonical nop: it keeps the sll shape but must not write or drive an ALU op.
   assign nop  = (inst == 32'd0);
   assign wreg = i_add | i_sub | i_and | i_or | i_xor | i_sll | i_srl | i_sra |
                 i_addi | i_andi | i_ori | i_xori | i_lw | i_lui | i_jal;
   assign sext = i_addi | i_lw | i_sw | i_beq | i_bne;
   assign uses_rs = i_add | i_sub | i_and | i_or | i_xor | i_jr | i_addi | i_andi |
                    i_ori | i_xori | i_lw | i_sw | i_beq | i_bne;
   assign uses_rt = i_add | i_sub | i_and | i_or | i_xor | i_sll | i_srl | i_sra |
                    i_sw | i_beq | i_bne;

   // Register file clears asynchronously; register 0 is never written and always reads zero.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
      end else if (wwreg && (wrn != 5'd0)) begin
         regs[wrn] <= wdi;
      end
   end

   assign rf_a = (rs == 5'd0) ? 32'd0 : (wwreg && (wrn == rs)) ? wdi : regs[rs];
   assign rf_b = (rt == 5'd0) ? 32'd0 : (wwreg && (wrn == rt)) ? wdi : regs[rt];

`ifdef PIPE_ID_FWD_EN
   // Youngest producer wins; a load still in EX cannot forward and is handled by the stall.
   always_comb begin
      da = rf_a;
      if (ewreg && !em2reg && (ern != 5'd0) && (ern == rs)) da = ealu;
      else if (mwreg && (mrn != 5'd0) && (mrn == rs)) da = mm2reg ? mmo : malu;
      db = rf_b;
      if (ewreg && !em2reg && (ern != 5'd0) && (ern == rt)) db = ealu;
      else if (mwreg && (mrn != 5'd0) && (mrn == rt)) db = mm2reg ? mmo : malu;
   end

   assign stall = ewreg && em2reg && (ern != 5'd0) &&
                  ((uses_rs && (ern == rs)) || (uses_rt && (ern == rt)));
`else
   logic unused_fwd;
   assign unused_fwd = ^{em2reg, mm2reg, ealu, malu, mmo};
   assign da = rf_a;
   assign db = rf_b;

   assign stall = (ewreg && (ern != 5'd0) && ((uses_rs && (ern == rs)) || (uses_rt && (ern == rt)))) ||
                  (mwreg && (mrn != 5'd0) && ((uses_rs && (mrn == rs)) || (uses_rt && (mrn == rt))));
`endif

   assign wpcir   = !stall;
   assign dwreg   = wreg && !nop && !stall;
   assign dwmem   = i_sw && !stall;
   assign dm2reg  = i_lw;
   assign daluimm = i_addi | i_andi | i_ori | i_xori | i_lw | i_sw | i_lui;
   assign dshift  = i_sll | i_srl | i_sra;
   assign djal    = i_jal;
   assign drn     = i_jal ? 5'd31 : (r_type ? rd : rt);
   assign dimm    = dshift ? {27'd0, sa} : (sext ? {{16{imm[15]}}, imm} : {16'd0, imm});
   assign bpc     = dpc4 + {{14{imm[15]}}, imm, 2'b00};
   assign jpc     = {dpc4[31:28], inst[25:0], 2'b00};

   always_comb begin
      daluc = 4'b0000;
      if (i_sub || i_beq || i_bne)       daluc = 4'b0100;
      else if (i_and || i_andi)          daluc = 4'b0001;
      else if (i_or || i_ori)            daluc = 4'b0101;
      else if (i_xor || i_xori)          daluc = 4'b0010;
      else if (i_lui)                    daluc = 4'b0110;
      else if (i_sll)                    daluc = 4'b0011;
      else if (i_srl)                    daluc = 4'b0111;
      else if (i_sra)                    daluc = 4'b1111;
      if (nop) daluc = 4'b0000;
   end

   // Branches resolve on the final operands; a stalled instruction must not redirect the PC.
   always_comb begin
      pcsource = 2'b00;
      if (!stall) begin
         if ((i_beq && (da == db)) || (i_bne && (da != db))) pcsource = 2'b01;
         else if (i_jr)                                       pcsource = 2'b10;
         else if (i_j || i_jal)                               pcsource = 2'b11;
      end
   end

endmodule
